// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and helpers for the oversampling UART receiver.
//   uart_rx_state_t : receiver FSM state encoding (PARITY present only when
//                     UART_RX_PARITY_EN is defined)
//   SAMPLE_A/B/C    : tick indices at which a bit is sampled for the majority vote
//   LAST_TICK       : final tick index of a bit period
//   calc_div        : clocks per oversample tick
//   maj3/even_parity: bit-level helpers
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_rx_state_t;

    localparam logic [3:0] SAMPLE_A  = 4'd7;
    localparam logic [3:0] SAMPLE_B  = 4'd8;
    localparam logic [3:0] SAMPLE_C  = 4'd9;
    localparam logic [3:0] LAST_TICK = 4'd15;

    // Truncating division: clocks per oversample tick.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Even-parity bit over a byte (value that makes the total count of ones even).
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// uart_rx_oversample_if: serial input and byte/status outputs of the UART receiver.
//   rx          : serial line (idles high)
//   data_out    : last received byte
//   data_valid  : one-cycle strobe, good byte
//   framing_err : one-cycle strobe, stop bit sampled low
//   parity_err  : one-cycle strobe, parity mismatch
//   busy        : receiver not idle
// master = receiver, slave = line driver / byte consumer.
interface uart_rx_oversample_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_err;
    logic       parity_err;
    logic       busy;

    modport master (
        input  rx,
        output data_out, data_valid, framing_err, parity_err, busy
    );

    modport slave (
        output rx,
        input  data_out, data_valid, framing_err, parity_err, busy
    );
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle tick every DIV clocks.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   clr   : synchronous clear; holds the count at 0 so the next tick lands
//           exactly DIV clocks after clr drops
//   tick  : registered one-cycle pulse
// Shared with the transmit side.
module uart_baud_tick #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count and tick; tick is registered alongside the count it decodes.
    always_comb begin
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = !clr && (cnt_d == CNT_MAX);
    end

    // Divider state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x-oversampling UART receiver (8N1, or 8E1 when the
// macro UART_RX_PARITY_EN is defined) feeding an RX FIFO write port.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : uart_rx_oversample_if.master (rx in; data_out, data_valid,
//           framing_err, parity_err, busy out)
// Each bit is sampled at ticks 7/8/9 and resolved by majority vote. A start
// bit that votes high is discarded as a glitch. The stop bit is decided at
// tick 9 and the FSM leaves immediately, so back-to-back frames are caught.
// After a low stop bit the receiver waits for the line to return high so a
// break is not mistaken for a new start bit.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_rx_oversample_if.master bus
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);

    uart_rx_state_t state_q, state_d;
    logic [1:0]     rx_sync_q, rx_sync_d;
    logic [3:0]     tick_idx_q, tick_idx_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [1:0]     samp_q, samp_d;
    logic [7:0]     data_out_q, data_out_d;
    logic           data_valid_q, data_valid_d;
    logic           framing_err_q, framing_err_d;
    logic           busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic           parity_err_q, parity_err_d;
    logic           par_bad_q, par_bad_d;
`endif

    logic rx_s, tick_s, tick_clr_s, maj_s, at_c_s, at_last_s;

    assign rx_s       = rx_sync_q[1];
    assign tick_clr_s = (state_q == IDLE);
    // Samples A and B were captured on earlier ticks; C is the live value.
    assign maj_s      = maj3(samp_q[0], samp_q[1], rx_s);
    assign at_c_s     = tick_s && (tick_idx_q == SAMPLE_C);
    assign at_last_s  = tick_s && (tick_idx_q == LAST_TICK);

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr_s),
        .tick  (tick_s)
    );

    // Next-state, datapath and output strobe logic.
    always_comb begin
        rx_sync_d     = {rx_sync_q[0], bus.rx};
        state_d       = state_q;
        tick_idx_d    = tick_s ? (tick_idx_q + 4'd1) : tick_idx_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        framing_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d  = 1'b0;
        par_bad_d     = par_bad_q;
`endif
        if (tick_s && (tick_idx_q == SAMPLE_A)) begin
            samp_d = {samp_q[1], rx_s};
        end else if (tick_s && (tick_idx_q == SAMPLE_B)) begin
            samp_d = {rx_s, samp_q[0]};
        end else begin
            samp_d = samp_q;
        end

        case (state_q)
            IDLE: begin
                tick_idx_d = 4'd0;
                bit_cnt_d  = 3'd0;
                if (!rx_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (at_c_s && maj_s) begin
                    state_d = IDLE;           // glitch, not a start bit
                end else if (at_last_s) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (at_c_s) begin
                    shift_d = {maj_s, shift_q[7:1]};   // LSB arrives first
                end else begin
                    shift_d = shift_q;
                end
                if (at_last_s) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_c_s) begin
                    par_bad_d = (maj_s != even_parity(shift_q));
                end else begin
                    par_bad_d = par_bad_q;
                end
                if (at_last_s) begin
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            STOP: begin
                if (at_c_s) begin
                    data_out_d = shift_q;
                    if (!maj_s) begin
                        framing_err_d = 1'b1;  // framing wins over parity
                        state_d       = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d  = 1'b1;
                        state_d       = IDLE;
`endif
                    end else begin
                        data_valid_d  = 1'b1;
                        state_d       = IDLE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            rx_sync_q     <= 2'b11;
            tick_idx_q    <= 4'd0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            samp_q        <= 2'b00;
            data_out_q    <= 8'h00;
            data_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q  <= 1'b0;
            par_bad_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rx_sync_q     <= rx_sync_d;
            tick_idx_q    <= tick_idx_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            samp_q        <= samp_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            framing_err_q <= framing_err_d;
            busy_q        <= busy_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q  <= parity_err_d;
            par_bad_q     <= par_bad_d;
`endif
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.framing_err = framing_err_q;
    assign bus.busy        = busy_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = parity_err_q;
`else
    assign bus.parity_err  = 1'b0;
`endif
endmodule

// File: doc/uart_rx_oversample.md
# uart_rx_oversample

16x-oversampling UART receiver that converts the serial `rx` line into bytes written into the RX FIFO of the UART FIFO system. It sits directly upstream of the RX FIFO write port. It presents each byte on `data_out` with a one-cycle `data_valid` strobe, the same write handshake the FIFO already accepts. It rejects glitches on the start bit and flags framing (and optional parity) errors.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `OVERSAMPLE`, default 16: ticks per bit. Fixed at 16; other values are unsupported.
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `rx`  input  1  asynchronous serial line; idles high.
- `data_out`  output  8  last received byte.
- `data_valid`  output  1  one-cycle pulse when a byte is good.
- `framing_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `parity_err`  output  1  one-cycle pulse on parity mismatch. Tied 0 when parity is compiled out.
- `busy`  output  1  high in every state except IDLE.

## Operation
- **Input sync:** 2-flop synchronizer on `rx`. Both flops reset to 1. All logic uses the synchronized value `rx_s`.
- **Tick generation:**
  - Divider `DIV = CLK_FREQ/(BAUD*OVERSAMPLE)`, truncating integer division (325 at the defaults).
  - One-cycle `tick` every DIV clocks.
  - The divider is cleared to 0 on IDLE exit, so tick phase aligns to the start edge.
- **Bit timing:** a 4-bit tick index runs 0..15 within each bit. Samples are taken at ticks 7, 8 and 9. Bit value = 2-of-3 majority.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_HIGH.
  - **IDLE:** `rx_s`==0 → START. The divider and tick index are cleared.
  - **START:** decision at tick 9. Majority 1 is a false start → IDLE, no outputs. Majority 0 continues; at tick 15 → DATA.
  - **DATA:** 8 bits, LSB first, shifted into an 8-bit register. The bit counter runs 0..7. At tick 15 of bit 7 → PARITY if compiled in, otherwise STOP.
  - **PARITY:** sample the parity bit. At tick 15 → STOP.
  - **STOP:** decision at tick 9, then leave the state immediately, without waiting for tick 15.
    - Majority 1 and no parity error: load `data_out`, pulse `data_valid` → IDLE.
    - Majority 1 with parity error: load `data_out`, pulse `parity_err`, no `data_valid` → IDLE.
    - Majority 0 (framing error or break): load `data_out`, pulse `framing_err`, no `data_valid` → WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rx_s`==1, then → IDLE. This prevents a break condition from being read as a start bit.
- **Priority:** if the stop bit is low and parity is also wrong, only `framing_err` pulses.
- **Output hold:** `data_out` holds its value until the next STOP decision.
- **Reset:** any assertion, including mid-frame, aborts the frame.
  - All outputs go to 0 and the FSM goes to IDLE.
  - The shift register, counters and divider clear; the sync flops go to 1.

## Timing
- **Reset values:** `data_out`=8'h00; `data_valid`, `framing_err`, `parity_err` and `busy` all 0.
- **Latency:** from the falling edge on `rx` to the `data_valid` rising edge is 2 sync cycles + (16 + 128 + 10) ticks × DIV, ±2 clk.
  - Without parity: 154 × 325 + 2 = 50052 clk ≈ 1.001 ms at the defaults.
  - With parity: add 16 × DIV.
- **Strobes:** each is exactly one `clk` cycle wide and asserted in the same cycle that `data_out` updates.
- **Back-to-back frames:** the FSM returns to IDLE 6 ticks before the end of the stop bit. A start edge arriving exactly at the stop-bit boundary must be captured.
- **Error tolerance:** receiver baud error up to ±3% must decode correctly.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **When defined:**
  - A 9th bit (even parity over the 8 data bits) is expected after the data bits.
  - The PARITY state exists and `parity_err` is live.
- **When undefined:**
  - The frame is 8N1 and the PARITY state is absent.
  - `parity_err` is constant 0.

## Structure
- **Package `uart_pkg`:**
  - The state enum `uart_rx_state_t`.
  - Localparams `SAMPLE_A`=7, `SAMPLE_B`=8, `SAMPLE_C`=9, `LAST_TICK`=15.
  - The DIV calculation function.
- **Sub-module `uart_baud_tick`:**
  - Divider with a synchronous clear input and a `tick` output.
  - Reusable by the TX side.

## Test plan
- **Single byte:** send 0xA5 8N1 at 9600 → exactly one `data_valid`, `data_out`=8'hA5, at 50052±2 clk after the start edge; no error pulses.
- **Back-to-back:** send 0x00, 0xFF, 0x55 with zero idle between frames → three `data_valid` pulses with the bytes in order.
- **Glitch:** drive `rx` low for 3 ticks (975 clk), then high → no outputs, `busy` back to 0 within 10 ticks.
- **Framing and break:** send 0x3C with the stop bit low, then hold `rx` low for 2 frames → one `framing_err`, no `data_valid`, `data_out`=8'h3C, FSM stays in WAIT_HIGH until `rx` rises; a following 0x81 is then received correctly.
- **Parity (`UART_RX_PARITY_EN`):** 0x07 with parity bit 0 → `parity_err`, no `data_valid`; 0x07 with parity bit 1 → `data_valid`, `data_out`=8'h07.
- **Reset mid-frame and baud skew:** assert `reset` during data bit 4 → all outputs 0 immediately, and the next 0x5A is received correctly; repeat 0x5A with the TX baud at +3% and −3% → correct reception.
